// File: rtl/message_gen_sequencer.sv
// message_gen_sequencer: frame sequencer for one message-generation channel.
// Walks the chip index, counts code repeats per message bit, steps the
// message bit address and drives the rail enables / timestamp-patch strobe.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   start, stop, abort       single-cycle control pulses
//   cfg_*                    channel configuration (sampled per frame)
//   sys_time_sync_done       UTC time valid
//   sys_utc_time_second      UTC seconds; any change is a second tick
//   dac_valid                one chip advance per asserted cycle
//   pcode_addr, msg_addr     chip index and message bit index
//   message_i/q_enable       rail enables
//   tstamp_patch_en          timestamp patch strobe
//   frame_start, frame_done  one-cycle pulses on first / last chip
//   busy                     not IDLE
//   frame_count              completed frames since leaving IDLE (wraps)
module message_gen_sequencer #(
    parameter int PCODE_LEN     = 40920,
    parameter int PCODE_REPEATS = 10,
    parameter int MESSAGE_LEN   = 120,
    localparam int PW = (PCODE_LEN > 1) ? $clog2(PCODE_LEN) : 1,
    localparam int RW = (PCODE_REPEATS > 1) ? $clog2(PCODE_REPEATS) : 1,
    localparam int MW = (MESSAGE_LEN > 1) ? $clog2(MESSAGE_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          abort,
    input  logic          cfg_align_sync,
    input  logic          cfg_single_shot,
    input  logic          cfg_tstamp_en,
    input  logic          cfg_i_en,
    input  logic          cfg_q_en,
    input  logic          sys_time_sync_done,
    input  logic [5:0]    sys_utc_time_second,
    input  logic          dac_valid,
    output logic [PW-1:0] pcode_addr,
    output logic [MW-1:0] msg_addr,
    output logic          message_i_enable,
    output logic          message_q_enable,
    output logic          tstamp_patch_en,
    output logic          frame_start,
    output logic          frame_done,
    output logic          busy,
    output logic [15:0]   frame_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [PW-1:0] PC_LAST  = PW'(PCODE_LEN - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(PCODE_REPEATS - 1);
    localparam logic [MW-1:0] MSG_LAST = MW'(MESSAGE_LEN - 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pcode_q, pcode_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [MW-1:0] msg_q, msg_d;
    logic          i_en_q, i_en_d;
    logic          q_en_q, q_en_d;
    logic          ts_en_q, ts_en_d;
    logic          fs_q, fs_d;
    logic          fd_q, fd_d;
    logic          busy_q, busy_d;
    logic [15:0]   fc_q, fc_d;
    logic          stop_q, stop_d;
    logic [5:0]    sec_q;

    logic pc_wrap;
    logic rep_wrap;
    logic msg_wrap;
    logic at_zero;
    logic sec_tick;
    logic go_idle;
    logic load_cfg;

    assign pc_wrap  = (pcode_q == PC_LAST);
    assign rep_wrap = (rep_q == REP_LAST);
    assign msg_wrap = (msg_q == MSG_LAST);
    assign at_zero  = (pcode_q == '0) && (rep_q == '0) && (msg_q == '0);
    assign sec_tick = (sys_utc_time_second != sec_q);

    always_comb begin
        state_d  = state_q;
        pcode_d  = pcode_q;
        rep_d    = rep_q;
        msg_d    = msg_q;
        i_en_d   = i_en_q;
        q_en_d   = q_en_q;
        ts_en_d  = ts_en_q;
        fs_d     = 1'b0;
        fd_d     = 1'b0;
        fc_d     = fc_q;
        stop_d   = stop_q;
        go_idle  = 1'b0;
        load_cfg = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    fc_d = '0;
                    if (cfg_align_sync) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d  = S_RUN;
                        load_cfg = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (stop) begin
                    go_idle = 1'b1;
                end else if (sys_time_sync_done && sec_tick) begin
                    state_d  = S_RUN;
                    load_cfg = 1'b1;
                end
            end
            S_RUN: begin
                stop_d = stop_q | stop;
                if (dac_valid) begin
                    // counters are all zero exactly on chip 0 of a frame
                    fs_d = at_zero;
                    if (pc_wrap) begin
                        pcode_d = '0;
                        if (rep_wrap) begin
                            rep_d = '0;
                            msg_d = msg_wrap ? '0 : msg_q + MW'(1);
                        end else begin
                            rep_d = rep_q + RW'(1);
                        end
                    end else begin
                        pcode_d = pcode_q + PW'(1);
                    end
                    if (pc_wrap && rep_wrap && msg_wrap) begin
                        fd_d = 1'b1;
                        fc_d = fc_q + 16'd1;
                        // a stop arriving on the last chip still counts
                        if (stop_q || stop || cfg_single_shot) begin
                            go_idle = 1'b1;
                        end else begin
                            load_cfg = 1'b1;
                        end
                    end
                end
            end
            default: go_idle = 1'b1;
        endcase

        // config only changes at RUN entry or a frame boundary
        if (load_cfg) begin
            i_en_d  = cfg_i_en;
            q_en_d  = cfg_q_en;
            ts_en_d = cfg_tstamp_en;
        end

        if (go_idle || abort) begin
            state_d = S_IDLE;
            pcode_d = '0;
            rep_d   = '0;
            msg_d   = '0;
            i_en_d  = 1'b0;
            q_en_d  = 1'b0;
            ts_en_d = 1'b0;
            stop_d  = 1'b0;
        end

        // abort beats start, stop and a coincident frame end
        if (abort) begin
            fc_d = '0;
            fs_d = 1'b0;
            fd_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pcode_q <= '0;
            rep_q   <= '0;
            msg_q   <= '0;
            i_en_q  <= 1'b0;
            q_en_q  <= 1'b0;
            ts_en_q <= 1'b0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
            fc_q    <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcode_q <= pcode_d;
            rep_q   <= rep_d;
            msg_q   <= msg_d;
            i_en_q  <= i_en_d;
            q_en_q  <= q_en_d;
            ts_en_q <= ts_en_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            busy_q  <= busy_d;
            fc_q    <= fc_d;
            stop_q  <= stop_d;
        end
    end

    // pure one-cycle delay for tick detection; kept running through reset
    always_ff @(posedge clk) begin
        sec_q <= sys_utc_time_second;
    end

    assign pcode_addr       = pcode_q;
    assign msg_addr         = msg_q;
    assign message_i_enable = i_en_q;
    assign message_q_enable = q_en_q;
    assign tstamp_patch_en  = ts_en_q;
    assign frame_start      = fs_q;
    assign frame_done       = fd_q;
    assign busy             = busy_q;
    assign frame_count      = fc_q;

endmodule

// File: tb/tb_message_gen_sequencer.sv
// tb_message_gen_sequencer: directed scenarios plus random stimulus,
// every cycle checked against a chip-count reference model.
module tb_message_gen_sequencer;

    localparam int PL = 4;
    localparam int PR = 2;
    localparam int ML = 3;
    localparam int FL = PL * PR * ML;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, stop, abort;
    logic       align, single, tsen, ien, qen, sync, valid;
    logic [5:0] sec;

    logic [1:0]  pcode_addr;
    logic [1:0]  msg_addr;
    logic        i_out, q_out, ts_out, fs_out, fd_out, busy_out;
    logic [15:0] fc_out;

    message_gen_sequencer #(
        .PCODE_LEN(PL), .PCODE_REPEATS(PR), .MESSAGE_LEN(ML)
    ) dut (
        .clk(clk), .rst(rst),
        .start(start), .stop(stop), .abort(abort),
        .cfg_align_sync(align), .cfg_single_shot(single),
        .cfg_tstamp_en(tsen), .cfg_i_en(ien), .cfg_q_en(qen),
        .sys_time_sync_done(sync), .sys_utc_time_second(sec),
        .dac_valid(valid),
        .pcode_addr(pcode_addr), .msg_addr(msg_addr),
        .message_i_enable(i_out), .message_q_enable(q_out),
        .tstamp_patch_en(ts_out),
        .frame_start(fs_out), .frame_done(fd_out),
        .busy(busy_out), .frame_count(fc_out)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // reference model: mode 0 idle, 1 waiting for sync, 2 running;
    // m_k = chips consumed in the current frame
    int         m_mode = 0;
    int         m_k    = 0;
    int         m_fc   = 0;
    bit         m_stop, m_ien, m_qen, m_ts, m_fs, m_fd;
    logic [5:0] m_prev_sec = '0;

    function automatic void m_idle();
        m_mode = 0;
        m_k    = 0;
        m_stop = 0;
        m_ien  = 0;
        m_qen  = 0;
        m_ts   = 0;
    endfunction

    function automatic void m_sample();
        m_ien = ien;
        m_qen = qen;
        m_ts  = tsen;
    endfunction

    function automatic void model_step();
        bit tk;
        tk = (sec != m_prev_sec);
        m_prev_sec = sec;
        m_fs = 0;
        m_fd = 0;
        if (rst) begin
            m_idle();
            m_fc = 0;
            return;
        end
        if (abort) begin
            m_idle();
            m_fc = 0;
            return;
        end
        case (m_mode)
            0: if (start) begin
                m_fc = 0;
                if (align) m_mode = 1;
                else begin
                    m_mode = 2;
                    m_k = 0;
                    m_sample();
                end
            end
            1: if (stop) m_idle();
               else if (sync && tk) begin
                   m_mode = 2;
                   m_k = 0;
                   m_sample();
               end
            default: begin
                m_stop = m_stop | stop;
                if (valid) begin
                    m_fs = (m_k == 0);
                    m_k++;
                    if (m_k == FL) begin
                        m_k = 0;
                        m_fd = 1;
                        m_fc = (m_fc + 1) & 16'hffff;
                        if (m_stop || single) m_idle();
                        else m_sample();
                    end
                end
            end
        endcase
    endfunction

    task automatic compare_all();
        chk("pcode_addr", pcode_addr, m_k % PL);
        chk("msg_addr", msg_addr, m_k / (PL * PR));
        chk("busy", busy_out, (m_mode != 0));
        chk("i_enable", i_out, m_ien);
        chk("q_enable", q_out, m_qen);
        chk("tstamp_en", ts_out, m_ts);
        chk("frame_start", fs_out, m_fs);
        chk("frame_done", fd_out, m_fd);
        chk("frame_count", fc_out, m_fc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        compare_all();
        start = 0;
        stop  = 0;
        abort = 0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  fd_seen;
        bit  stopped;
        bit  seen_fs2;
        rst = 1; start = 0; stop = 0; abort = 0;
        align = 0; single = 0; tsen = 0; ien = 0; qen = 0;
        sync = 0; sec = 6'd0; valid = 0;

        repeat (3) step();
        rst = 0;
        step();

        // single shot, continuous valid
        single = 1; ien = 1; qen = 0; tsen = 1; valid = 1;
        start = 1;
        step();
        fd_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (fd_out) fd_seen++;
        end
        chk("ss_frames", fd_seen, 1);
        chk("ss_count", fc_out, 1);
        chk("ss_idle", busy_out, 0);

        // continuous, 50% valid, stop at chip 10 of frame 2
        single = 0;
        start = 1;
        step();
        stopped = 0;
        for (int i = 0; i < 400 && m_mode != 0; i++) begin
            valid = 1'($urandom_range(0, 1));
            if (m_fc == 1 && m_k == 10 && !stopped) begin
                stop = 1;
                stopped = 1;
            end
            step();
        end
        chk("stop_seen", stopped, 1);
        chk("stop_idle", busy_out, 0);
        chk("stop_frames", fc_out, 2);

        // sync alignment
        align = 1; sync = 0; sec = 6'd5; valid = 1; ien = 1;
        step();
        start = 1;
        step();
        sec = 6'd6;
        step();
        step();
        chk("ws_waiting", busy_out, 1);
        chk("ws_no_run", i_out, 0);
        sync = 1;
        step();
        chk("ws_no_tick", i_out, 0);
        sec = 6'd7;
        step();
        chk("ws_run_entry", i_out, 1);
        chk("ws_pcode0", pcode_addr, 0);
        abort = 1;
        step();

        // abort on the frame-end chip
        align = 0; single = 0; valid = 1;
        start = 1;
        step();
        for (int i = 0; i < 40 && m_k != FL - 1; i++) step();
        chk("ab_reach_end", m_k, FL - 1);
        abort = 1;
        step();
        chk("ab_fc", fc_out, 0);
        chk("ab_fd", fd_out, 0);
        chk("ab_idle", busy_out, 0);
        step();
        chk("ab_no_fs", fs_out, 0);
        start = 1; abort = 1;
        step();
        chk("ab_start_idle", busy_out, 0);
        step();
        chk("ab_still_idle", busy_out, 0);

        // config sampling: toggle i_en mid-frame
        ien = 0; qen = 1; tsen = 1;
        start = 1;
        step();
        for (int i = 0; i < 10; i++) step();
        ien = 1;
        seen_fs2 = 0;
        for (int i = 0; i < 40 && !seen_fs2; i++) begin
            step();
            chk("cfg_ts_high", ts_out, 1);
            if (fs_out && fc_out == 1) begin
                seen_fs2 = 1;
                chk("cfg_ien_next", i_out, 1);
            end else if (fc_out == 0) begin
                chk("cfg_ien_hold", i_out, 0);
            end
        end
        chk("cfg_fs2_seen", seen_fs2, 1);
        abort = 1;
        step();

        // reset at chip 13
        start = 1;
        step();
        for (int i = 0; i < 40 && m_k != 13; i++) step();
        chk("rst_reach13", pcode_addr, 1);
        rst = 1;
        step();
        chk("rst_busy", busy_out, 0);
        chk("rst_pcode", pcode_addr, 0);
        chk("rst_msg", msg_addr, 0);
        chk("rst_ien", i_out, 0);
        chk("rst_ts", ts_out, 0);
        rst = 0;
        start = 1;
        step();
        chk("rst_restart", busy_out, 1);
        chk("rst_rs_pcode", pcode_addr, 0);
        chk("rst_rs_msg", msg_addr, 0);
        abort = 1;
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            valid  = ($urandom_range(0, 3) != 0);
            start  = ($urandom_range(0, 30) == 0);
            stop   = ($urandom_range(0, 90) == 0);
            abort  = ($urandom_range(0, 200) == 0);
            rst    = ($urandom_range(0, 600) == 0);
            sync   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) sec = (sec == 6'd59) ? 6'd0 : sec + 6'd1;
            if ($urandom_range(0, 20) == 0) align  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 20) == 0) single = 1'($urandom_range(0, 1));
            ien  = 1'($urandom_range(0, 1));
            qen  = 1'($urandom_range(0, 1));
            tsen = 1'($urandom_range(0, 1));
            step();
            rst = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/message_gen_sequencer.md
# message_gen_sequencer

Frame sequencer for one message-generation channel. It walks the pseudo-code chip index, counts code repeats per message bit, and advances the message bit address. It also raises the channel enables and the timestamp-patch strobe. Frame starts are optionally aligned to the system UTC second once time sync is done.

## Interface
Parameters:
- PCODE_LEN, 40920, chips per code period
- PCODE_REPEATS, 10, code periods per message bit
- MESSAGE_LEN, 120, message bits per frame

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous and active-high
- start  in  1  single-cycle pulse; requests frame transmission
- stop  in  1  single-cycle pulse; graceful stop at the next frame boundary
- abort  in  1  single-cycle pulse; immediate return to IDLE
- cfg_align_sync  in  1  1 = first frame waits for time sync plus a second tick
- cfg_single_shot  in  1  1 = send one frame, then return to IDLE
- cfg_tstamp_en  in  1  request timestamp patching while running
- cfg_i_en, cfg_q_en  in  1 each  per-rail enable requests
- sys_time_sync_done  in  1  UTC time valid
- sys_utc_time_second  in  6  UTC seconds; a change of value is a second tick
- dac_valid  in  1  one chip-advance strobe per asserted cycle
- pcode_addr  out  $clog2(PCODE_LEN)  chip index
- msg_addr  out  $clog2(MESSAGE_LEN)  message bit index
- message_i_enable, message_q_enable  out  1 each  rail enables
- tstamp_patch_en  out  1  timestamp patch strobe
- frame_start  out  1  pulse on the first chip of each frame
- frame_done  out  1  pulse on the last chip of each frame
- busy  out  1  high in any state except IDLE
- frame_count  out  16  completed frames since leaving IDLE; wraps

## Operation
- States: IDLE, WAIT_SYNC, RUN.
- IDLE
  - Counters, enables and tstamp_patch_en are 0.
  - start with cfg_align_sync=1 goes to WAIT_SYNC.
  - start with cfg_align_sync=0 goes to RUN.
  - frame_count clears on the start.
- WAIT_SYNC
  - Goes to RUN on the first cycle where sys_time_sync_done=1 and a second tick is detected.
  - Second tick: sys_utc_time_second differs from its 1-cycle-delayed copy.
  - A tick in the same cycle as the start pulse is not counted.
- RUN, on each cycle with dac_valid=1:
  - pcode_addr increments.
  - At PCODE_LEN-1, pcode_addr wraps to 0 and the repeat counter increments.
  - At repeat PCODE_REPEATS-1, the repeat counter wraps and msg_addr increments.
  - At MESSAGE_LEN-1, msg_addr wraps to 0; that chip is the frame end.
- Frame end
  - frame_done pulses and frame_count increments.
  - If stop was latched, or cfg_single_shot=1, go to IDLE.
  - Otherwise stay in RUN and pulse frame_start on the next valid chip.
- No dac_valid: counters hold and outputs hold.
- Enables in RUN:
  - message_i_enable = cfg_i_en, message_q_enable = cfg_q_en.
  - tstamp_patch_en = cfg_tstamp_en.
  - Config bits are sampled once at RUN entry and again at each frame boundary, never mid-frame.
- stop
  - Latched in WAIT_SYNC or RUN; cleared on entering IDLE.
  - stop in WAIT_SYNC goes to IDLE at once.
  - stop in the same cycle as the frame end is honoured at that frame end.
- abort
  - From any state, returns to IDLE next cycle with all counters cleared.
  - abort wins over start, stop and frame end in the same cycle.
- start while busy is ignored.

## Timing
- All outputs are registered and change on the cycle after the qualifying dac_valid or state transition.
- Reset: every output is 0, state is IDLE, and the stop latch is clear.
- Entry into RUN
  - pcode_addr=0 and msg_addr=0 on the entry cycle.
  - frame_start pulses one cycle after the first dac_valid seen in RUN.
  - Enables rise on the entry cycle.
- Frame length is exactly PCODE_LEN*PCODE_REPEATS*MESSAGE_LEN dac_valid strobes.
- frame_done and frame_start are each one cycle wide.
- For back-to-back frames:
  - frame_done (last chip) and the next frame_start (chip 0) are separated by exactly one valid strobe.
  - That strobe is the one that wraps the counters.
- Exit to IDLE: enables drop in the same cycle counters clear, one cycle after the frame end, stop or abort.
- rst mid-frame: the next cycle is IDLE with all outputs 0, identical to power-on.

## Test plan
Use PCODE_LEN=4, PCODE_REPEATS=2, MESSAGE_LEN=3 (24 chips per frame) unless noted.
- Single shot: cfg_single_shot=1, cfg_align_sync=0, start, dac_valid always 1.
  - pcode_addr goes 0..3 twice per msg_addr, and msg_addr goes 0,1,2.
  - frame_done comes on the 24th chip, frame_count=1, then IDLE and busy=0.
- Continuous with stop: continuous mode, dac_valid duty 50%, stop pulsed during chip 10 of frame 2.
  - Exactly 2 frames complete (frame_count=2), then IDLE.
  - Counters hold on every dac_valid=0 cycle.
- Sync alignment: cfg_align_sync=1, start, sys_time_sync_done=0 while the second changes 5→6.
  - Stays in WAIT_SYNC.
  - Assert sync_done, then second 6→7: RUN entered the following cycle.
- Abort precedence: abort in the same cycle as the frame end.
  - IDLE next cycle, frame_count reset to 0, no frame_start.
  - start and abort together from IDLE: remains IDLE.
- Config sampling: cfg_i_en toggled mid-frame has no effect until the next frame_start.
  - With cfg_tstamp_en=1, tstamp_patch_en is high throughout RUN.
- Reset mid-run: rst at chip 13.
  - All outputs 0 next cycle; start afterwards begins from pcode_addr=0, msg_addr=0.
